// File: rtl/booth_mac_seq.sv
// Sequential radix-8 Booth multiply-accumulate: one Booth digit per cycle through one shared adder.
// Optional BOOTH_EARLY_TERM_EN: stop iterating once the remaining multiplier bits are all zero.
module booth_mac_seq #(
  parameter int WIDTH  = 32,
  parameter int GROUPS = (WIDTH + 2) / 3,
  parameter int ACC_W  = 2 * WIDTH + 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             busy
);
  localparam int PW = 2 * WIDTH + 3;
  localparam int CW = $clog2(GROUPS);
  localparam int BW = WIDTH + 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PREP = 2'd1;
  localparam logic [1:0] ITER = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r, b_r;
  logic             clr_r;
  logic [WIDTH+1:0] a3;
  logic [PW-1:0]    prod;
  logic [CW-1:0]    cnt;
  logic [ACC_W-1:0] acc;

  logic [CW+1:0]    sh;
  logic [BW-1:0]    bext;
  logic [3:0]       win, dig, mag;
  logic             neg, last;
  logic [WIDTH+1:0] pp;
  logic [PW-1:0]    ppx, term, prod_nx;

  // b[-1] sits at bext[0]; bits above WIDTH-1 read as zero
  always_comb begin
    sh   = {1'b0, cnt, 1'b0} + {2'b0, cnt};
    bext = {3'b0, b_r, 1'b0};
    win  = bext[sh +: 4];
    dig  = (win[3] ? 4'b1100 : 4'b0000) + {2'b0, win[2], 1'b0} + {3'b0, win[1]} + {3'b0, win[0]};
    neg  = dig[3];
    mag  = neg ? (4'd0 - dig) : dig;
    case (mag)
      4'd1:    pp = {2'b0, a_r};
      4'd2:    pp = {1'b0, a_r, 1'b0};
      4'd3:    pp = a3;
      4'd4:    pp = {a_r, 2'b0};
      default: pp = '0;
    endcase
    ppx     = {{(PW-WIDTH-2){1'b0}}, pp};
    term    = (neg ? (PW'(0) - ppx) : ppx) << sh;
    prod_nx = prod + term;
`ifdef BOOTH_EARLY_TERM_EN
    last = (cnt == CW'(GROUPS - 1)) || ((b_r >> (sh + (CW+2)'(2))) == '0);
`else
    last = (cnt == CW'(GROUPS - 1));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      clr_r <= 1'b0;
      a3    <= '0;
      prod  <= '0;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= in_a;
          b_r   <= in_b;
          clr_r <= in_clr;
          prod  <= '0;
          state <= PREP;
        end
        PREP: begin
          a3    <= {2'b0, a_r} + {1'b0, a_r, 1'b0};
          cnt   <= '0;
          state <= ITER;
        end
        ITER: begin
          prod <= prod_nx;
          cnt  <= cnt + CW'(1);
          if (last) begin
            acc   <= (clr_r ? '0 : acc) + {{(ACC_W-2*WIDTH){1'b0}}, prod_nx[2*WIDTH-1:0]};
            state <= DONE;
          end
        end
        default: if (out_ready) state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign acc_out   = acc;
endmodule

// File: tb/tb_booth_mac_seq.sv
// Directed plus randomized bench for booth_mac_seq against an integer-arithmetic MAC model.
module tb_booth_mac_seq;
  localparam int WIDTH  = 32;
  localparam int GROUPS = (WIDTH + 2) / 3;
  localparam int ACC_W  = 2 * WIDTH + 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0, in_ready, in_clr = 1'b0;
  logic [WIDTH-1:0] in_a = '0, in_b = '0;
  logic             out_valid, out_ready = 1'b0, busy;
  logic [ACC_W-1:0] acc_out;

  int tests = 0, fails = 0;
  logic [ACC_W-1:0] acc_m = '0;

  booth_mac_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_clr(in_clr), .out_valid(out_valid),
    .out_ready(out_ready), .acc_out(acc_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // posedges from the accept edge until out_valid is first seen
  function automatic int exp_lat(input logic [WIDTH-1:0] b);
`ifdef BOOTH_EARLY_TERM_EN
    for (int i = 0; i < GROUPS; i++)
      if ((64'(b) >> (3 * i + 2)) == 64'd0) return 2 + i;
`endif
    return GROUPS + 1;
  endfunction

  task automatic do_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic clr, input int hold);
    int n;
    logic [ACC_W-1:0] snap;
    logic [2*WIDTH-1:0] p;
    @(negedge clk);
    chk({tag, ":in_ready"}, ACC_W'(in_ready), ACC_W'(1));
    in_a = a; in_b = b; in_clr = clr; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    p = 64'(a) * 64'(b);
    acc_m = (clr ? '0 : acc_m) + ACC_W'(p);
    n = 0;
    while (n < 100) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (out_valid) break;
    end
    chk({tag, ":latency"}, ACC_W'(n), ACC_W'(exp_lat(b)));
    chk({tag, ":acc"}, acc_out, acc_m);
    snap = acc_out;
    for (int k = 0; k < hold; k++) begin
      in_valid = k[0];
      in_a = $urandom; in_b = $urandom;
      @(negedge clk);
      chk({tag, ":hold_valid"}, ACC_W'(out_valid), ACC_W'(1));
      chk({tag, ":hold_ready"}, ACC_W'(in_ready), ACC_W'(0));
      chk({tag, ":hold_acc"}, acc_out, snap);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ":release_valid"}, ACC_W'(out_valid), ACC_W'(0));
    chk({tag, ":release_ready"}, ACC_W'(in_ready), ACC_W'(1));
  endtask

  initial begin
    #2;
    chk("reset:in_ready", ACC_W'(in_ready), ACC_W'(1));
    chk("reset:out_valid", ACC_W'(out_valid), ACC_W'(0));
    chk("reset:busy", ACC_W'(busy), ACC_W'(0));
    chk("reset:acc", acc_out, '0);
    #10 rst_n = 1'b1;

    do_op("a3b5", 32'd3, 32'd5, 1'b1, 0);
    do_op("a2b7", 32'd2, 32'd7, 1'b0, 0);
    do_op("a10b4", 32'd10, 32'd4, 1'b0, 5);
    do_op("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
    do_op("b1", 32'd1234567, 32'd1, 1'b1, 0);
    do_op("bmsb", 32'hDEAD_BEEF, 32'h8000_0000, 1'b0, 0);

    // reset dropped mid-ITER, then a fresh accumulate from zero
    @(negedge clk);
    in_a = 32'd99; in_b = 32'd77; in_clr = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst:in_ready", ACC_W'(in_ready), ACC_W'(1));
    chk("midrst:out_valid", ACC_W'(out_valid), ACC_W'(0));
    chk("midrst:busy", ACC_W'(busy), ACC_W'(0));
    chk("midrst:acc", acc_out, '0);
    acc_m = '0;
    @(negedge clk) rst_n = 1'b1;
    do_op("a6b7", 32'd6, 32'd7, 1'b0, 0);

    for (int r = 0; r < 12; r++)
      do_op("rand", $urandom, $urandom, ($urandom_range(0, 3) == 0), r % 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
